// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
// Shares the single register-file write port between the in-order pipeline
// writeback and out-of-band long-latency results (mul/div, future
// non-blocking loads). The pipeline has default priority. Long-latency results
// are buffered in a DEPTH-entry FIFO and drained on idle writeback cycles.
// When the FIFO is empty and the pipeline is idle, a long-latency result
// bypasses the FIFO and is written in the same cycle.
//
// Optional feature, macro WB_ARB_STARVE_GUARD_EN: a wait counter and a FORCE
// state. These stall writeback for one cycle so that a FIFO head waiting
// MAX_WAIT cycles retires. Without the macro, wb_stall is tied low.
//
// Parameters: DEPTH (FIFO entries, power of two, >= 2), MAX_WAIT (1..255).
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   pipe_we/pipe_rd/pipe_data  WB stage write request
//   ll_valid/ll_rd/ll_data     long-latency result; ll_ready accepts it
//   rf_we/rf_rd/rf_data        register-file write port (combinational)
//   wb_stall                   WB stage must hold its pipe_* values
//   pending, fifo_count        FIFO non-empty / occupancy
module wb_port_arbiter #(
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pipe_we,
  input  logic [4:0]               pipe_rd,
  input  logic [31:0]              pipe_data,
  input  logic                     ll_valid,
  output logic                     ll_ready,
  input  logic [4:0]               ll_rd,
  input  logic [31:0]              ll_data,
  output logic                     rf_we,
  output logic [4:0]               rf_rd,
  output logic [31:0]              rf_data,
  output logic                     wb_stall,
  output logic                     pending,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("wb_port_arbiter: DEPTH must be a power of two >= 2");
  end
  if (MAX_WAIT < 1 || MAX_WAIT > 255) begin : g_bad_wait
    $error("wb_port_arbiter: MAX_WAIT must be in 1..255");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PEND  = 2'd1,
    FORCE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [4:0]       mem_rd_q   [DEPTH];
  logic [31:0]      mem_data_q [DEPTH];

  logic pipe_act;
  logic fifo_empty;
  logic push_acc;
  logic ll_live;
  logic force_act;
  logic grant_pipe, grant_head, grant_byp;
  logic pop;
  logic push_store;

  assign pipe_act   = pipe_we && (pipe_rd != 5'd0);
  assign fifo_empty = (count_q == {CW{1'b0}});
  assign ll_ready   = (count_q < DEPTH_C) && !rst;
  assign push_acc   = ll_valid && ll_ready;
  // An accepted push to x0 is swallowed here: it never writes or occupies.
  assign ll_live    = push_acc && (ll_rd != 5'd0);

`ifdef WB_ARB_STARVE_GUARD_EN
  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);
  logic [7:0] wait_q, wait_d;
  assign force_act = (state_q == FORCE);
`else
  assign force_act = 1'b0;
`endif

  // Port grant in priority order: forced head, pipeline, head, bypass.
  always_comb begin
    grant_pipe = 1'b0;
    grant_head = 1'b0;
    grant_byp  = 1'b0;
    if (rst) begin
      grant_pipe = 1'b0;
    end else if (force_act) begin
      grant_head = 1'b1;
    end else if (pipe_act) begin
      grant_pipe = 1'b1;
    end else if (!fifo_empty) begin
      grant_head = 1'b1;
    end else if (ll_live) begin
      grant_byp = 1'b1;
    end else begin
      grant_pipe = 1'b0;
    end
  end

  assign pop        = grant_head;
  assign push_store = ll_live && !grant_byp;

  // Drive the register-file port from whichever source holds the grant.
  always_comb begin
    rf_we   = 1'b0;
    rf_rd   = 5'd0;
    rf_data = 32'd0;
    if (grant_pipe) begin
      rf_we   = 1'b1;
      rf_rd   = pipe_rd;
      rf_data = pipe_data;
    end else if (grant_head) begin
      rf_we   = 1'b1;
      rf_rd   = mem_rd_q[rd_ptr_q];
      rf_data = mem_data_q[rd_ptr_q];
    end else if (grant_byp) begin
      rf_we   = 1'b1;
      rf_rd   = ll_rd;
      rf_data = ll_data;
    end else begin
      rf_we   = 1'b0;
    end
  end

  assign wb_stall   = force_act && !rst;
  assign pending    = !fifo_empty && !rst;
  assign fifo_count = count_q;

  // Occupancy and pointer next-state. A simultaneous push and pop leaves the count unchanged.
  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_store) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_store, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

`ifdef WB_ARB_STARVE_GUARD_EN
  // The wait counter restarts on every pop, so it measures how long the current head has waited.
  always_comb begin
    wait_d = wait_q;
    if (pop || state_q == IDLE) begin
      wait_d = 8'd0;
    end else if (state_q == PEND && wait_q < MAX_WAIT_C) begin
      wait_d = wait_q + 8'd1;
    end else begin
      wait_d = wait_q;
    end
  end
`endif

  // FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (count_d != {CW{1'b0}}) state_d = PEND;
        else                       state_d = IDLE;
      end
      PEND: begin
        if (count_d == {CW{1'b0}}) state_d = IDLE;
`ifdef WB_ARB_STARVE_GUARD_EN
        else if (wait_d == MAX_WAIT_C) state_d = FORCE;
`endif
        else                       state_d = PEND;
      end
      FORCE: begin
        if (count_d == {CW{1'b0}}) state_d = IDLE;
        else                       state_d = PEND;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      count_q  <= {CW{1'b0}};
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
`ifdef WB_ARB_STARVE_GUARD_EN
      wait_q   <= 8'd0;
`endif
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
`ifdef WB_ARB_STARVE_GUARD_EN
      wait_q   <= wait_d;
`endif
    end
  end

  // FIFO storage. Contents need no reset because the occupancy count qualifies every read.
  always_ff @(posedge clk) begin
    if (push_store) begin
      mem_rd_q[wr_ptr_q]   <= ll_rd;
      mem_data_q[wr_ptr_q] <= ll_data;
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter (DEPTH=2, MAX_WAIT=4). The bench uses a
// table of per-cycle vectors, then hand sequences for the guard/no-guard
// behaviour and reset during operation. Inputs are driven 1 time unit after
// the rising edge. The combinational outputs are sampled 3 units later,
// well before the next edge.
module tb_wb_port_arbiter;

  logic        clk;
  logic        rst;
  logic        pipe_we;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_data;
  logic        ll_valid;
  logic        ll_ready;
  logic [4:0]  ll_rd;
  logic [31:0] ll_data;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_data;
  logic        wb_stall;
  logic        pending;
  logic [1:0]  fifo_count;

  int passed;
  int total;

  wb_port_arbiter #(.DEPTH(2), .MAX_WAIT(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .pipe_we   (pipe_we),
    .pipe_rd   (pipe_rd),
    .pipe_data (pipe_data),
    .ll_valid  (ll_valid),
    .ll_ready  (ll_ready),
    .ll_rd     (ll_rd),
    .ll_data   (ll_data),
    .rf_we     (rf_we),
    .rf_rd     (rf_rd),
    .rf_data   (rf_data),
    .wb_stall  (wb_stall),
    .pending   (pending),
    .fifo_count(fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        pw;
    logic [4:0]  prd;
    logic [31:0] pdata;
    logic        lv;
    logic [4:0]  lrd;
    logic [31:0] ldata;
    logic        e_we;
    logic [4:0]  e_rd;
    logic [31:0] e_data;
    logic        e_ready;
    logic        e_stall;
    logic        e_pend;
    logic [1:0]  e_cnt;
  } vec_t;

  vec_t vecs [16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else passed++;
  endtask

  task automatic drive(input logic pw, input logic [4:0] prd, input logic [31:0] pdata,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] ldata);
    pipe_we   = pw;
    pipe_rd   = prd;
    pipe_data = pdata;
    ll_valid  = lv;
    ll_rd     = lrd;
    ll_data   = ldata;
  endtask

  task automatic chk_port(input string nm, input logic we, input logic [4:0] rd,
                          input logic [31:0] data);
    chk({nm, " rf_we"}, 32'(rf_we), 32'(we));
    chk({nm, " rf_rd"}, 32'(rf_rd), 32'(rd));
    chk({nm, " rf_data"}, rf_data, data);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    rst    = 1'b1;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

    //           pw    prd    pdata         lv    lrd    ldata          we    rd     data           rdy   stl   pnd   cnt
    vecs[0]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,         1'b1, 1'b0, 1'b0, 2'd0};
    vecs[1]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd5,  32'hDEADBEEF,  1'b1, 5'd5,  32'hDEADBEEF,  1'b1, 1'b0, 1'b0, 2'd0};
    vecs[2]  = '{1'b1, 5'd3,  32'h11,       1'b1, 5'd7,  32'h22,        1'b1, 5'd3,  32'h11,        1'b1, 1'b0, 1'b0, 2'd0};
    vecs[3]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,         1'b1, 5'd7,  32'h22,        1'b1, 1'b0, 1'b1, 2'd1};
    vecs[4]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,         1'b1, 1'b0, 1'b0, 2'd0};
    vecs[5]  = '{1'b1, 5'd1,  32'hA1,       1'b1, 5'd8,  32'h88,        1'b1, 5'd1,  32'hA1,        1'b1, 1'b0, 1'b0, 2'd0};
    vecs[6]  = '{1'b1, 5'd2,  32'hA2,       1'b1, 5'd9,  32'h99,        1'b1, 5'd2,  32'hA2,        1'b1, 1'b0, 1'b1, 2'd1};
    vecs[7]  = '{1'b1, 5'd3,  32'hA3,       1'b1, 5'd10, 32'h1010,      1'b1, 5'd3,  32'hA3,        1'b0, 1'b0, 1'b1, 2'd2};
    vecs[8]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd10, 32'h1010,      1'b1, 5'd8,  32'h88,        1'b0, 1'b0, 1'b1, 2'd2};
    vecs[9]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd10, 32'h1010,      1'b1, 5'd9,  32'h99,        1'b1, 1'b0, 1'b1, 2'd1};
    vecs[10] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,         1'b1, 5'd10, 32'h1010,      1'b1, 1'b0, 1'b1, 2'd1};
    vecs[11] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,         1'b1, 1'b0, 1'b0, 2'd0};
    vecs[12] = '{1'b1, 5'd4,  32'h44,       1'b1, 5'd11, 32'hBB,        1'b1, 5'd4,  32'h44,        1'b1, 1'b0, 1'b0, 2'd0};
    vecs[13] = '{1'b1, 5'd0,  32'h55,       1'b0, 5'd0,  32'h0,         1'b1, 5'd11, 32'hBB,        1'b1, 1'b0, 1'b1, 2'd1};
    vecs[14] = '{1'b1, 5'd0,  32'h55,       1'b1, 5'd0,  32'h66,        1'b0, 5'd0,  32'h0,         1'b1, 1'b0, 1'b0, 2'd0};
    vecs[15] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,         1'b1, 1'b0, 1'b0, 2'd0};

    // Reset state, with pipe_we asserted to show rf_we is gated by rst.
    drive(1'b1, 5'd6, 32'h6, 1'b1, 5'd6, 32'h6);
    #3;
    chk("reset fifo_count", 32'(fifo_count), 32'd0);
    chk("reset ll_ready", 32'(ll_ready), 32'd0);
    chk("reset rf_we", 32'(rf_we), 32'd0);
    chk("reset pending", 32'(pending), 32'd0);
    chk("reset wb_stall", 32'(wb_stall), 32'd0);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    next_cycle();
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].pw, vecs[i].prd, vecs[i].pdata, vecs[i].lv, vecs[i].lrd, vecs[i].ldata);
      #3;
      chk_port($sformatf("v%0d", i), vecs[i].e_we, vecs[i].e_rd, vecs[i].e_data);
      chk($sformatf("v%0d ll_ready", i), 32'(ll_ready), 32'(vecs[i].e_ready));
      chk($sformatf("v%0d wb_stall", i), 32'(wb_stall), 32'(vecs[i].e_stall));
      chk($sformatf("v%0d pending", i), 32'(pending), 32'(vecs[i].e_pend));
      chk($sformatf("v%0d fifo_count", i), 32'(fifo_count), 32'(vecs[i].e_cnt));
      next_cycle();
    end

    // Starvation: pipeline busy every cycle, one buffered entry for x13.
    drive(1'b1, 5'd12, 32'hC0, 1'b1, 5'd13, 32'hD13);
    #3;
    chk_port("starve push", 1'b1, 5'd12, 32'hC0);
    next_cycle();
`ifdef WB_ARB_STARVE_GUARD_EN
    for (int c = 1; c <= 4; c++) begin
      drive(1'b1, 5'd12, 32'hC0 + 32'(c), 1'b0, 5'd0, 32'd0);
      #3;
      chk_port($sformatf("guard wait%0d", c), 1'b1, 5'd12, 32'hC0 + 32'(c));
      chk($sformatf("guard wait%0d stall", c), 32'(wb_stall), 32'd0);
      chk($sformatf("guard wait%0d pending", c), 32'(pending), 32'd1);
      next_cycle();
    end
    // The stalled pipeline holds its values while the head is forced out.
    drive(1'b1, 5'd12, 32'hC5, 1'b0, 5'd0, 32'd0);
    #3;
    chk_port("guard force", 1'b1, 5'd13, 32'hD13);
    chk("guard force stall", 32'(wb_stall), 32'd1);
    chk("guard force count", 32'(fifo_count), 32'd1);
    next_cycle();
    #3;
    chk_port("guard resume", 1'b1, 5'd12, 32'hC5);
    chk("guard resume stall", 32'(wb_stall), 32'd0);
    chk("guard resume pending", 32'(pending), 32'd0);
    next_cycle();
`else
    for (int c = 1; c <= 10; c++) begin
      drive(1'b1, 5'd12, 32'hC0 + 32'(c), 1'b0, 5'd0, 32'd0);
      #3;
      chk_port($sformatf("noguard hold%0d", c), 1'b1, 5'd12, 32'hC0 + 32'(c));
      chk($sformatf("noguard hold%0d stall", c), 32'(wb_stall), 32'd0);
      chk($sformatf("noguard hold%0d pending", c), 32'(pending), 32'd1);
      next_cycle();
    end
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    #3;
    chk_port("noguard drain", 1'b1, 5'd13, 32'hD13);
    next_cycle();
    #3;
    chk("noguard drained pending", 32'(pending), 32'd0);
    next_cycle();
`endif

    // Reset while the FIFO holds two entries.
    drive(1'b1, 5'd14, 32'h1, 1'b1, 5'd15, 32'hF15);
    next_cycle();
    drive(1'b1, 5'd14, 32'h2, 1'b1, 5'd16, 32'hF16);
    next_cycle();
    drive(1'b1, 5'd20, 32'h3, 1'b1, 5'd17, 32'hF17);
    #1;
    chk("prefill count", 32'(fifo_count), 32'd2);
    chk("prefill ll_ready", 32'(ll_ready), 32'd0);
    rst = 1'b1;
    #2;
    chk("midrst fifo_count", 32'(fifo_count), 32'd0);
    chk("midrst ll_ready", 32'(ll_ready), 32'd0);
    chk("midrst rf_we", 32'(rf_we), 32'd0);
    chk("midrst pending", 32'(pending), 32'd0);
    chk("midrst wb_stall", 32'(wb_stall), 32'd0);
    next_cycle();
    rst = 1'b0;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    #3;
    chk("post-rst ll_ready", 32'(ll_ready), 32'd1);
    chk("post-rst fifo_count", 32'(fifo_count), 32'd0);
    chk("post-rst rf_we", 32'(rf_we), 32'd0);
    chk("post-rst pending", 32'(pending), 32'd0);
    next_cycle();
    #3;
    chk("post-rst flushed rf_we", 32'(rf_we), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
